// File: rtl/fwd_mux_reg_pkg.sv
// Shared definitions for the forwarding mux: default widths, source encodings
// and the register-update action type.
// Imported by the interface, the priority matcher and the top level so that
// the hazard logic and the source decoder agree on one encoding.
package fwd_mux_reg_pkg;

   // Default widths for the MIPS core pipeline.
   localparam int DEF_WIDTH = 32;   // operand / channel data width
   localparam int DEF_NCH   = 3;    // forwarding channels: E, M, W
   localparam int DEF_AW    = 5;    // register address width
   localparam int DEF_CNTW  = 16;   // forward-hit counter width

   // Source encoding carried in q_src: 0 is the register file,
   // channel i is reported as i+1.
   localparam int SRC_RF = 0;

   function automatic int src_ch(input int idx);
      return idx + 1;
   endfunction

   // What the output register does on the next clock edge (reset is
   // handled directly in the register process and is not listed here).
   typedef enum logic [1:0] {
      ACT_CAPTURE = 2'd0,   // load the selected operand, mark valid
      ACT_FLUSH   = 2'd1,   // insert a bubble on request of the pipeline
      ACT_HOLD    = 2'd2,   // external freeze, keep everything
      ACT_BUBBLE  = 2'd3    // load-use hazard, insert a bubble
   } upd_act_e;

endpackage

// File: rtl/fwd_mux_reg_if.sv
// Operand request bus: source register address, register-file value and the
// packed forwarding channels (valid, ready, destination address, data).
// Channel i occupies [i*AW +: AW] of ch_addr and [i*WIDTH +: WIDTH] of ch_data.
// master drives the request, slave (the forwarding mux) consumes it.
interface fwd_mux_reg_if #(
   parameter int WIDTH = fwd_mux_reg_pkg::DEF_WIDTH,
   parameter int NCH   = fwd_mux_reg_pkg::DEF_NCH,
   parameter int AW    = fwd_mux_reg_pkg::DEF_AW
);

   logic [AW-1:0]        rs_addr;    // source register address
   logic [WIDTH-1:0]     rf_data;    // register-file read value for rs_addr
   logic [NCH-1:0]       ch_valid;   // channel i writes a register this cycle
   logic [NCH-1:0]       ch_ready;   // channel i data already produced
   logic [NCH*AW-1:0]    ch_addr;    // packed destination addresses
   logic [NCH*WIDTH-1:0] ch_data;    // packed channel data

   modport master (
      output rs_addr,
      output rf_data,
      output ch_valid,
      output ch_ready,
      output ch_addr,
      output ch_data
   );

   modport slave (
      input rs_addr,
      input rf_data,
      input ch_valid,
      input ch_ready,
      input ch_addr,
      input ch_data
   );

endinterface

// File: rtl/fwd_mux_reg_match.sv
// Priority matcher: finds the youngest forwarding channel writing rs_addr.
// Latency: purely combinational, zero cycles.
// Backpressure: pending flags a youngest match whose data is not produced yet.
// Ports: rs_addr, ch_valid, ch_ready, ch_addr in; hit (youngest match ready),
//        sel_idx (index of youngest match), pending (youngest match not ready) out.
module fwd_match #(
   parameter int NCH = fwd_mux_reg_pkg::DEF_NCH,
   parameter int AW  = fwd_mux_reg_pkg::DEF_AW,
   parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic [AW-1:0]     rs_addr,
   input  logic [NCH-1:0]    ch_valid,
   input  logic [NCH-1:0]    ch_ready,
   input  logic [NCH*AW-1:0] ch_addr,
   output logic              hit,
   output logic [IW-1:0]     sel_idx,
   output logic              pending
);

   logic [NCH-1:0] match;
   logic           found;
   logic           first_rdy;

   // Register 0 is hard-wired to zero in MIPS, so a write to it is never
   // forwarded even if a stage claims to produce one.
   always_comb begin
      match = '0;
      for (int i = 0; i < NCH; i++) begin
         match[i] = ch_valid[i] && (ch_addr[i*AW +: AW] == rs_addr) && (rs_addr != '0);
      end
   end

   // Walk from the oldest channel to the youngest so that the last
   // assignment, i.e. the lowest index, wins. The ready bit is taken from
   // that same channel only: older matches never hide a pending load.
   always_comb begin
      found     = 1'b0;
      sel_idx   = '0;
      first_rdy = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (match[i]) begin
            found     = 1'b1;
            sel_idx   = IW'(i);
            first_rdy = ch_ready[i];
         end
      end
   end

   assign hit     = found && first_rdy;
   assign pending = found && !first_rdy;

endmodule

// File: rtl/fwd_mux_reg.sv
// Forwarding mux with registered output: picks rs operand from regfile or the
// youngest forwarding channel and captures it into the next pipeline register.
// Latency: one cycle inputs -> q; hz_stall is combinational (zero cycles).
// Backpressure: stall holds all outputs; hz_stall requests an upstream stall
//   and loads a bubble; flush loads a bubble and overrides both.
// Ports: clk, reset (sync, active-high), stall, flush, bus (operand request,
//   slave side); hz_stall, q, q_src (0 = regfile, i+1 = channel i), q_valid,
//   fwd_cnt (saturating count of channel-sourced captures).
module fwd_mux_reg
   import fwd_mux_reg_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int NCH   = DEF_NCH,
   parameter  int AW    = DEF_AW,
   parameter  int CNTW  = DEF_CNTW,
   localparam int SW    = $clog2(NCH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   fwd_mux_reg_if.slave      bus,
   output logic              hz_stall,
   output logic [WIDTH-1:0]  q,
   output logic [SW-1:0]     q_src,
   output logic              q_valid,
   output logic [CNTW-1:0]   fwd_cnt
);

   localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

   // ------------------------------------------------------------------
   // Match and select
   // ------------------------------------------------------------------
   logic          hit;
   logic          pending;
   logic [IW-1:0] sel_idx;

   fwd_match #(
      .NCH (NCH),
      .AW  (AW),
      .IW  (IW)
   ) u_match (
      .rs_addr  (bus.rs_addr),
      .ch_valid (bus.ch_valid),
      .ch_ready (bus.ch_ready),
      .ch_addr  (bus.ch_addr),
      .hit      (hit),
      .sel_idx  (sel_idx),
      .pending  (pending)
   );

   logic [WIDTH-1:0] ch_sel_dat;
   logic [WIDTH-1:0] nxt_dat;
   logic [SW-1:0]    nxt_src;

   always_comb begin
      ch_sel_dat = '0;
      for (int i = 0; i < NCH; i++) begin
         if (int'(sel_idx) == i) begin
            ch_sel_dat = bus.ch_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // $zero reads as zero regardless of regfile contents or channel traffic.
   // While pending the value chosen here is unused: a bubble is loaded.
   always_comb begin
      nxt_dat = bus.rf_data;
      nxt_src = SW'(SRC_RF);
      if (bus.rs_addr == '0) begin
         nxt_dat = '0;
         nxt_src = SW'(SRC_RF);
      end else if (hit) begin
         nxt_dat = ch_sel_dat;
         nxt_src = SW'(src_ch(int'(sel_idx)));
      end
   end

   // The load-use request goes out regardless of the external stall: the
   // upstream stage must keep stalling for as long as the load is outstanding.
   assign hz_stall = pending;

   // ------------------------------------------------------------------
   // Register update
   // ------------------------------------------------------------------
   upd_act_e act;

   always_comb begin
      act = ACT_CAPTURE;
      if (flush) begin
         act = ACT_FLUSH;
      end else if (stall) begin
         act = ACT_HOLD;
      end else if (pending) begin
         act = ACT_BUBBLE;
      end
   end

   logic [WIDTH-1:0] q_q,   q_d;
   logic [SW-1:0]    src_q, src_d;
   logic             vld_q, vld_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;

   always_comb begin
      q_d   = q_q;
      src_d = src_q;
      vld_d = vld_q;
      cnt_d = cnt_q;
      unique case (act)
         ACT_FLUSH, ACT_BUBBLE: begin
            // A bubble leaves the debug counter alone.
            q_d   = '0;
            src_d = SW'(SRC_RF);
            vld_d = 1'b0;
         end
         ACT_HOLD: begin
         end
         ACT_CAPTURE: begin
            q_d   = nxt_dat;
            src_d = nxt_src;
            vld_d = 1'b1;
            // Saturate rather than wrap so a long run never reads as "few".
            if ((nxt_src != SW'(SRC_RF)) && (cnt_q != {CNTW{1'b1}})) begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         q_q   <= '0;
         src_q <= '0;
         vld_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         src_q <= src_d;
         vld_q <= vld_d;
         cnt_q <= cnt_d;
      end
   end

   assign q       = q_q;
   assign q_src   = src_q;
   assign q_valid = vld_q;
   assign fwd_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_mux_reg.sv
// Bench for fwd_mux_reg: directed scenarios plus random traffic against a
// behavioural model of the forwarding rules, and a narrow-counter instance
// for the saturation case.
module tb_fwd_mux_reg;
   import fwd_mux_reg_pkg::*;

   localparam int WIDTH = 32;
   localparam int NCH   = 3;
   localparam int AW    = 5;
   localparam int CNTW  = 16;
   localparam int SW    = $clog2(NCH + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance
   logic             reset, stall, flush;
   logic             hz_stall;
   logic [WIDTH-1:0] q;
   logic [SW-1:0]    q_src;
   logic             q_valid;
   logic [CNTW-1:0]  fwd_cnt;

   fwd_mux_reg_if #(.WIDTH(WIDTH), .NCH(NCH), .AW(AW)) bus ();

   fwd_mux_reg #(.WIDTH(WIDTH), .NCH(NCH), .AW(AW), .CNTW(CNTW)) dut (
      .clk      (clk),
      .reset    (reset),
      .stall    (stall),
      .flush    (flush),
      .bus      (bus),
      .hz_stall (hz_stall),
      .q        (q),
      .q_src    (q_src),
      .q_valid  (q_valid),
      .fwd_cnt  (fwd_cnt)
   );

   // Narrow counter instance
   logic             reset2;
   logic             stall2, flush2;
   logic             hz2;
   logic [WIDTH-1:0] q2;
   logic [SW-1:0]    src2;
   logic             vld2;
   logic [1:0]       cnt2;

   fwd_mux_reg_if #(.WIDTH(WIDTH), .NCH(NCH), .AW(AW)) bus2 ();

   fwd_mux_reg #(.WIDTH(WIDTH), .NCH(NCH), .AW(AW), .CNTW(2)) dut2 (
      .clk      (clk),
      .reset    (reset2),
      .stall    (stall2),
      .flush    (flush2),
      .bus      (bus2),
      .hz_stall (hz2),
      .q        (q2),
      .q_src    (src2),
      .q_valid  (vld2),
      .fwd_cnt  (cnt2)
   );

   // Stimulus as plain arrays, packed onto the bus by apply()
   logic [AW-1:0]    t_rs;
   logic [WIDTH-1:0] t_rf;
   logic             t_v [NCH];
   logic             t_r [NCH];
   logic [AW-1:0]    t_a [NCH];
   logic [WIDTH-1:0] t_d [NCH];

   // Reference state
   logic [WIDTH-1:0] m_q;
   int               m_src;
   logic             m_vld;
   int               m_cnt;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      bus.rs_addr = t_rs;
      bus.rf_data = t_rf;
      for (int i = 0; i < NCH; i++) begin
         bus.ch_valid[i]              = t_v[i];
         bus.ch_ready[i]              = t_r[i];
         bus.ch_addr[i*AW +: AW]      = t_a[i];
         bus.ch_data[i*WIDTH +: WIDTH] = t_d[i];
      end
   endtask

   task automatic clear_ch();
      for (int i = 0; i < NCH; i++) begin
         t_v[i] = 1'b0;
         t_r[i] = 1'b0;
         t_a[i] = '0;
         t_d[i] = '0;
      end
   endtask

   task automatic rand_inputs();
      t_rs = AW'($urandom_range(0, 3));
      t_rf = $urandom;
      for (int i = 0; i < NCH; i++) begin
         t_v[i] = 1'($urandom_range(0, 1));
         t_r[i] = ($urandom_range(0, 3) != 0);
         t_a[i] = AW'($urandom_range(0, 3));
         t_d[i] = $urandom;
      end
   endtask

   // Forwarding rules: youngest writer of rs wins, $zero is always zero,
   // an unproduced youngest value means load-use hazard.
   task automatic model_next(output logic hz, output logic [WIDTH-1:0] nv, output int ns);
      int first;
      first = -1;
      for (int i = 0; i < NCH; i++) begin
         if (first < 0 && t_v[i] && t_a[i] == t_rs && t_rs != 0) first = i;
      end
      hz = 1'b0;
      nv = '0;
      ns = 0;
      if (t_rs == 0) begin
         nv = '0;
      end else if (first < 0) begin
         nv = t_rf;
      end else if (t_r[first]) begin
         nv = t_d[first];
         ns = first + 1;
      end else begin
         hz = 1'b1;
      end
   endtask

   // Apply stimulus, check the hazard output, step one edge, check registers.
   task automatic cycle(input string tag);
      logic             hz;
      logic [WIDTH-1:0] nv;
      int               ns;
      apply();
      #1;
      model_next(hz, nv, ns);
      chk({tag, "_hz"}, 32'(hz_stall), 32'(hz));
      @(posedge clk);
      if (reset) begin
         m_q = '0; m_src = 0; m_vld = 1'b0; m_cnt = 0;
      end else if (flush) begin
         m_q = '0; m_src = 0; m_vld = 1'b0;
      end else if (stall) begin
         // hold
      end else if (hz) begin
         m_q = '0; m_src = 0; m_vld = 1'b0;
      end else begin
         m_q = nv; m_src = ns; m_vld = 1'b1;
         if (ns != 0 && m_cnt < (1 << CNTW) - 1) m_cnt++;
      end
      #1;
      chk({tag, "_q"},     q,              m_q);
      chk({tag, "_src"},   32'(q_src),     32'(m_src));
      chk({tag, "_vld"},   32'(q_valid),   32'(m_vld));
      chk({tag, "_cnt"},   32'(fwd_cnt),   32'(m_cnt));
      @(negedge clk);
   endtask

   initial begin
      m_q = '0; m_src = 0; m_vld = 1'b0; m_cnt = 0;
      stall = 1'b0; flush = 1'b0; reset = 1'b1;
      reset2 = 1'b1; stall2 = 1'b0; flush2 = 1'b0;
      bus2.rs_addr = '0; bus2.rf_data = '0; bus2.ch_valid = '0;
      bus2.ch_ready = '0; bus2.ch_addr = '0; bus2.ch_data = '0;
      clear_ch();
      t_rs = '0; t_rf = '0;

      // Reset for two cycles with random inputs
      for (int k = 0; k < 2; k++) begin
         rand_inputs();
         stall = 1'($urandom_range(0, 1));
         flush = 1'($urandom_range(0, 1));
         cycle("rst");
      end
      chk("rst_q_zero", q, 32'h0);
      chk("rst_cnt_zero", 32'(fwd_cnt), 32'h0);
      reset = 1'b0; stall = 1'b0; flush = 1'b0;

      // Youngest of two ready matches wins
      clear_ch();
      t_rs = 5'd8; t_rf = 32'h11;
      t_v[1] = 1'b1; t_r[1] = 1'b1; t_a[1] = 5'd8; t_d[1] = 32'h22;
      t_v[2] = 1'b1; t_r[2] = 1'b1; t_a[2] = 5'd8; t_d[2] = 32'h33;
      cycle("prio");
      chk("prio_q_const",   q,             32'h22);
      chk("prio_src_const", 32'(q_src),    32'd2);
      chk("prio_cnt_const", 32'(fwd_cnt),  32'd1);

      // $zero ignores a channel claiming to write it
      clear_ch();
      t_rs = 5'd0; t_rf = 32'h1234;
      t_v[0] = 1'b1; t_r[0] = 1'b1; t_a[0] = 5'd0; t_d[0] = 32'hFF;
      cycle("zero");
      chk("zero_q_const",   q,            32'h0);
      chk("zero_cnt_const", 32'(fwd_cnt), 32'd1);

      // Load-use: youngest match pending, older ready match must not be used
      clear_ch();
      t_rs = 5'd4; t_rf = 32'h44;
      t_v[0] = 1'b1; t_r[0] = 1'b0; t_a[0] = 5'd4; t_d[0] = 32'h0;
      t_v[1] = 1'b1; t_r[1] = 1'b1; t_a[1] = 5'd4; t_d[1] = 32'h55;
      cycle("lu_bub");
      chk("lu_bub_vld_const", 32'(q_valid), 32'd0);
      t_r[0] = 1'b1; t_d[0] = 32'h66;
      cycle("lu_go");
      chk("lu_go_q_const",   q,          32'h66);
      chk("lu_go_src_const", 32'(q_src), 32'd1);

      // Capture, freeze for three cycles, then flush wins over stall
      clear_ch();
      t_rs = 5'd5; t_rf = 32'hAA;
      cycle("cap");
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         rand_inputs();
         cycle("hold");
         chk("hold_q_const", q, 32'hAA);
      end
      flush = 1'b1;
      cycle("stfl");
      chk("stfl_vld_const", 32'(q_valid), 32'd0);
      stall = 1'b0; flush = 1'b0;

      // Reset in the middle of a stall clears everything including the counter
      clear_ch();
      t_rs = 5'd3; t_v[2] = 1'b1; t_r[2] = 1'b1; t_a[2] = 5'd3; t_d[2] = 32'h77;
      cycle("pre");
      stall = 1'b1; reset = 1'b1;
      cycle("rst_stall");
      chk("rst_stall_cnt_const", 32'(fwd_cnt), 32'd0);
      stall = 1'b0; reset = 1'b0;

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         rand_inputs();
         stall = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 19) == 0);
         reset = ($urandom_range(0, 49) == 0);
         cycle("rnd");
      end
      reset = 1'b0; stall = 1'b0; flush = 1'b0;

      // Narrow counter saturates at 3 and returns to 0 on reset
      @(negedge clk);
      reset2 = 1'b0;
      bus2.rs_addr = 5'd3;
      bus2.ch_valid = 3'b001;
      bus2.ch_ready = 3'b001;
      bus2.ch_addr[0 +: AW] = 5'd3;
      for (int k = 1; k <= 5; k++) begin
         bus2.ch_data[0 +: WIDTH] = $urandom;
         @(posedge clk);
         #1;
         chk("sat_cnt", 32'(cnt2), (k < 3) ? k : 3);
         @(negedge clk);
      end
      reset2 = 1'b1;
      @(posedge clk);
      #1;
      chk("sat_rst_cnt", 32'(cnt2), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
